// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, field widths and the default data width.
// Build option: define ALU_XOR_EN to make code 3'b100 a bitwise XOR instead of ADD.
package alu_pkg;

  localparam int unsigned data_w = 32;
  localparam int unsigned ctrl_w = 3;
  localparam int unsigned rd_w   = 5;

  // Codes not listed here (and 3'b100 without ALU_XOR_EN) execute as ADD.
`ifdef ALU_XOR_EN
  typedef enum logic [ctrl_w-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_e;
`else
  typedef enum logic [ctrl_w-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;
`endif

endpackage

// File: rtl/alu_ex_stage_if.sv
// Execute-stage handshake bundle: decode-side request and memory-side result.
interface alu_ex_stage_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = data_w
) ();

  logic              in_valid;
  logic              in_ready;
  logic [ctrl_w-1:0] ALUControl;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic [rd_w-1:0]   rd;
  logic              reg_write;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  alu_result;
  logic              zero;
  logic [rd_w-1:0]   out_rd;
  logic              out_reg_write;

  modport master (
    output in_valid, ALUControl, src_a, src_b, rd, reg_write, out_ready,
    input  in_ready, out_valid, alu_result, zero, out_rd, out_reg_write
  );

  modport slave (
    input  in_valid, ALUControl, src_a, src_b, rd, reg_write, out_ready,
    output in_ready, out_valid, alu_result, zero, out_rd, out_reg_write
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: (ALUControl, src_a, src_b) -> (result, zero).
// Build option: ALU_XOR_EN selects XOR for code 3'b100.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = data_w
) (
  input  logic [ctrl_w-1:0] alu_control,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [WIDTH-1:0]  result_c,
  output logic              zero_c
);

  always_comb begin
    result_c = src_a + src_b;
    case (alu_control)
      ALU_SUB: result_c = src_a - src_b;
      ALU_AND: result_c = src_a & src_b;
      ALU_OR:  result_c = src_a | src_b;
`ifdef ALU_XOR_EN
      ALU_XOR: result_c = src_a ^ src_b;
`endif
      ALU_SLT: result_c = WIDTH'($signed(src_a) < $signed(src_b));
      default: result_c = src_a + src_b;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ALU result into a two-entry skid pipeline register toward memory/writeback.
// Build option: ALU_XOR_EN (code 3'b100 as XOR), handled inside alu_core.
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = data_w
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  alu_ex_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [rd_w-1:0]  rd;
    logic             reg_write;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           new_entry;
  logic [WIDTH-1:0] result_c;
  logic             zero_c;
  logic             accept;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .alu_control (bus.ALUControl),
    .src_a       (bus.src_a),
    .src_b       (bus.src_b),
    .result_c    (result_c),
    .zero_c      (zero_c)
  );

  // in_ready depends only on the skid register, never on out_ready or in_valid.
  assign bus.in_ready = rst_n && (state_q != ST_SKID);
  assign accept       = bus.in_valid && bus.in_ready;

  assign new_entry = '{result: result_c, zero: zero_c, rd: bus.rd, reg_write: bus.reg_write};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept && bus.out_ready) begin
          main_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = ST_SKID;
        end else if (bus.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (bus.out_ready) begin
          main_d  = skid_q;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops every entry, including a same-cycle input transfer.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.out_valid     = (state_q != ST_EMPTY);
  assign bus.alu_result    = main_q.result;
  assign bus.zero          = main_q.zero;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_reg_write = main_q.reg_write;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed plan plus randomized traffic vs a queue model.
module tb_alu_ex_stage;

  localparam int unsigned W = 32;
`ifdef ALU_XOR_EN
  localparam bit xor_en = 1'b1;
`else
  localparam bit xor_en = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    logic         rw;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;

  alu_ex_stage_if #(.WIDTH(W)) bus ();

  alu_ex_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  exp_t         q[$];
  logic [W-1:0] popped[$];
  bit           rst_zero = 1'b1;
  bit           accepted = 1'b0;

  // Reference ALU straight from the operation table.
  function automatic logic [W-1:0] ref_alu(input logic [2:0] c, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (c)
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return xor_en ? (a ^ b) : (a + b);
      3'd5:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return a + b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", W'(bus.out_valid), W'(q.size() > 0));
    chk("in_ready", W'(bus.in_ready), W'(rst_n && (q.size() < 2)));
    if (q.size() > 0) begin
      chk("alu_result", bus.alu_result, q[0].res);
      chk("zero", W'(bus.zero), W'(q[0].res == '0));
      chk("out_rd", W'(bus.out_rd), W'(q[0].rd));
      chk("out_reg_write", W'(bus.out_reg_write), W'(q[0].rw));
    end else if (rst_zero) begin
      chk("rst_result", bus.alu_result, '0);
      chk("rst_sideband", W'({bus.zero, bus.out_rd, bus.out_reg_write}), '0);
    end
  endtask

  // One clock: predict transfers from pre-edge inputs, advance the model, check after the edge.
  task automatic tick();
    bit   do_out;
    bit   do_in;
    exp_t e;
    do_out = rst_n && !flush && (q.size() > 0) && bus.out_ready;
    do_in  = rst_n && !flush && bus.in_valid && (q.size() < 2);
    e.res  = ref_alu(bus.ALUControl, bus.src_a, bus.src_b);
    e.rd   = bus.rd;
    e.rw   = bus.reg_write;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      rst_zero = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (do_out) begin
        popped.push_back(q[0].res);
        void'(q.pop_front());
      end
      if (do_in) begin
        q.push_back(e);
        rst_zero = 1'b0;
      end
    end
    accepted = do_in;
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd);
    bus.in_valid   = 1'b1;
    bus.ALUControl = c;
    bus.src_a      = a;
    bus.src_b      = b;
    bus.rd         = rd;
    bus.reg_write  = rd[0];
  endtask

  task automatic op(input string tag, input logic [2:0] c, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] expv);
    drive(c, a, b, 5'd3);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, W'(bus.out_valid), W'(1));
    chk({tag, "_result"}, bus.alu_result, expv);
    chk({tag, "_zero"}, W'(bus.zero), W'(expv == '0));
  endtask

  logic [W-1:0] bp_exp[4];
  int           base;

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.ALUControl = 3'd0;
    bus.src_a      = '0;
    bus.src_b      = '0;
    bus.rd         = '0;
    bus.reg_write  = 1'b0;
    tick();
    tick();
    chk("reset_in_ready_low", W'(bus.in_ready), W'(0));
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", W'(bus.in_ready), W'(1));

    // Basic operations and wrap-around, one cycle after accept.
    op("add", 3'b000, 32'd5, 32'd7, 32'd12);
    op("sub", 3'b001, 32'd7, 32'd7, 32'd0);
    op("and", 3'b010, 32'hF0, 32'h3C, 32'h30);
    op("or", 3'b011, 32'hF0, 32'h0F, 32'hFF);
    op("slt_neg", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1);
    op("slt_pos", 3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0);
    op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    op("sub_wrap", 3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF);
    op("code100", 3'b100, 32'hF0, 32'hFF, xor_en ? 32'h0F : 32'h1EF);
    op("code110", 3'b110, 32'd40, 32'd2, 32'd42);
    op("code111", 3'b111, 32'd1, 32'd1, 32'd2);
    tick();

    // Backpressure: four ops, out_ready low until the skid entry is occupied.
    bus.out_ready = 1'b0;
    base = popped.size();
    for (int k = 0; k < 4; k++) begin
      int n;
      bp_exp[k] = 32'(100 * (k + 1)) + 32'(k);
      drive(3'b000, 32'(100 * (k + 1)), 32'(k), 5'(k + 8));
      n = 0;
      do begin
        tick();
        n++;
      end while (!accepted && n < 20);
      chk("bp_accepted", W'(accepted), W'(1));
      if (k == 1) begin
        chk("bp_in_ready_low", W'(bus.in_ready), W'(0));
        chk("bp_hold_op1", bus.alu_result, bp_exp[0]);
        tick();
        tick();
        chk("bp_hold_op1_later", bus.alu_result, bp_exp[0]);
        chk("bp_still_valid", W'(bus.out_valid), W'(1));
        bus.out_ready = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_drain_count", W'(popped.size() - base), W'(4));
    for (int i = 0; i < 4; i++) begin
      if (base + i < popped.size()) chk("bp_drain_order", popped[base + i], bp_exp[i]);
    end

    // Flush while in the skid state with a live input.
    bus.out_ready = 1'b0;
    drive(3'b011, 32'h1111_0000, 32'h0000_2222, 5'd17);
    tick();
    drive(3'b011, 32'h3333_0000, 32'h0000_4444, 5'd18);
    tick();
    chk("pre_flush_skid", W'(bus.in_ready), W'(0));
    drive(3'b011, 32'h5555_0000, 32'h0000_6666, 5'd19);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", W'(bus.out_valid), W'(0));
    chk("flush_in_ready", W'(bus.in_ready), W'(1));
    base = popped.size();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("flush_nothing_emitted", W'(popped.size() - base), W'(0));

    // Reset mid-stream with entries held.
    bus.out_ready = 1'b0;
    drive(3'b000, 32'd9, 32'd9, 5'd21);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_valid", W'(bus.out_valid), W'(0));
    chk("rst_mid_result", bus.alu_result, '0);
    chk("rst_mid_side", W'({bus.zero, bus.out_rd, bus.out_reg_write}), '0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    chk("rst_release_in_ready", W'(bus.in_ready), W'(1));

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      if ($urandom_range(0, 5) == 0) b = W'($urandom_range(0, 2));
      drive(3'($urandom_range(0, 7)), a, b, 5'($urandom));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 31) == 0);
      rst_n         = ($urandom_range(0, 99) != 0);
      tick();
    end
    flush        = 1'b0;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute-stage ALU with a registered, back-pressurable output. It consumes the 3-bit `ALUControl` code from the ALU decoder together with the two operands and the destination tag. It produces `alu_result`/`zero` into a valid/ready pipeline register that feeds the memory/writeback stage. A two-entry skid buffer keeps `in_ready` a registered signal, so decode-side stall logic never sees a combinational path from `out_ready`.

## Interface
- `WIDTH`, 32, operand/result width in bits
- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset, synchronous, active-low
- `flush` in 1: synchronous pipeline flush (branch mispredict/trap)
- `in_valid` in 1: upstream holds a valid operation
- `in_ready` out 1: stage can accept this cycle
- `ALUControl` in 3: operation code (000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT)
- `src_a`, `src_b` in WIDTH: operands
- `rd` in 5: destination register tag
- `reg_write` in 1: writeback enable, carried alongside the result
- `out_valid` out 1: result register holds a valid entry
- `out_ready` in 1: downstream accepts this cycle
- `alu_result` out WIDTH: registered result
- `zero` out 1: registered (result == 0)
- `out_rd` out 5, `out_reg_write` out 1: registered sideband

## Operation
- The result is computed combinationally from the inputs and captured on the transfer `in_valid && in_ready`.
- ADD/SUB wrap modulo 2^WIDTH. AND/OR are bitwise.
- SLT is a signed compare: result = {WIDTH-1 zeros, (signed src_a < signed src_b)}.
- Codes 100, 110 and 111 execute as ADD (see Configuration for 100).
- `zero` is computed from the same result and registered with it.
- State machine on {main_valid, skid_valid}:
  - EMPTY: main_valid=0, skid_valid=0
  - FULL: main_valid=1, skid_valid=0
  - SKID: main_valid=1, skid_valid=1
- `out_valid` = main_valid. `in_ready` = rst_n && !skid_valid.
- EMPTY, accept → FULL.
- FULL:
  - accept with out_ready=1 → FULL, main reloaded.
  - accept with out_ready=0 → SKID, entry goes into the skid register.
  - no accept with out_ready=1 → EMPTY.
- SKID: out_ready=1 → the skid entry moves to main → FULL. No input is accepted while in SKID.
- Outputs are stable while `out_valid && !out_ready`.
- Flush has priority over every other event. Next cycle: EMPTY, and any same-cycle input transfer is discarded.
- Reset mid-operation discards all entries, identical to flush plus clearing of the data registers.

## Timing
- Latency: one cycle from accepted input to `out_valid`.
- Throughput: one per cycle while `out_ready` stays high.
- Reset values: out_valid=0, alu_result=0, zero=0, out_rd=0, out_reg_write=0.
- `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- `zero` is meaningful only when `out_valid`=1.
- No combinational path from `out_ready` or `in_valid` to `in_ready`.
- The only combinational logic in front of the capture flops is operands → result.

## Configuration
- `ALU_XOR_EN` defined: code 100 performs bitwise XOR.
- `ALU_XOR_EN` undefined: code 100 performs ADD.
- All other behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg` holds:
  - the `alu_ctrl_e` enum with the codes above, shared with the decoder
  - the `ALU_XOR_EN`-dependent code list
  - the `data_w` default width constant
- One sub-module `alu_core`: purely combinational (ALUControl, src_a, src_b) → (result, zero).
- `alu_ex_stage` contains only the skid/handshake registers and instantiates `alu_core`.

## Test plan
- **Basic ops, `out_ready`=1:** ADD 5+7 → 12, zero=0. SUB 7−7 → 0, zero=1. AND F0&3C → 30. OR F0|0F → FF. Each appears one cycle after accept.
- **Signed SLT:** src_a=0xFFFFFFFF, src_b=1 → result 1. src_a=1, src_b=0xFFFFFFFF → result 0.
- **Wrap-around:** ADD 0xFFFFFFFF+1 → 0, zero=1. SUB 0−1 → 0xFFFFFFFF.
- **Backpressure:**
  - Stream 4 ops with out_ready=0 from cycle 2: in_ready drops after the second accept, and op1 holds stable on the output.
  - Raise out_ready: ops drain in order 1,2, followed by 3,4 accepted after in_ready returns. No loss or duplication.
- **Flush in SKID state with in_valid=1:** next cycle out_valid=0 and in_ready=1, and the flushed ops never appear.
- **Reset and code 100:**
  - Assert rst_n=0 mid-stream: next cycle all outputs are 0.
  - Code 100 with src_a=0xF0, src_b=0xFF → 0x0F with `ALU_XOR_EN` defined, 0x1EF without.
